// File: rtl/registrador_deslocamento_pkg.sv
// registrador_deslocamento_pkg: shared Tx command codes and etapa state codes
package registrador_deslocamento_pkg;
  typedef enum logic [1:0] {
    TX_RESET  = 2'b00,
    TX_LOAD   = 2'b01,
    TX_HOLD   = 2'b10,
    TX_SHIFTL = 2'b11
  } tx_t;
  typedef enum logic [1:0] {
    VAZIO      = 2'd0,
    CARREGADO  = 2'd1,
    DESLOCANDO = 2'd2,
    ESGOTADO   = 2'd3
  } etapa_t;
endpackage

// File: rtl/registrador_deslocamento.sv
// registrador_deslocamento: working register executing RESET/LOAD/HOLD/SHIFTL from Tx; ports clock, reset, Tx, entrada -> saida, carry, zero, n_shift, n_load, etapa, erro
module registrador_deslocamento
  import registrador_deslocamento_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int MAX_SHIFT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       Tx,
  input  logic [WIDTH-1:0] entrada,
  output logic [WIDTH-1:0] saida,
  output logic             carry,
  output logic             zero,
  output logic [2:0]       n_shift,
  output logic [1:0]       n_load,
  output logic [1:0]       etapa,
  output logic             erro
);
  etapa_t st;
  logic [2:0] ns_next;
  assign ns_next = n_shift + 3'd1;
  assign zero = (saida == '0);
  assign etapa = st;
  always_ff @(posedge clock) begin
    if (reset) begin
      saida <= '0;
      carry <= 1'b0;
      n_shift <= '0;
      n_load <= '0;
      st <= VAZIO;
      erro <= 1'b0;
    end else begin
      case (tx_t'(Tx))
        TX_RESET: begin
          saida <= '0;
          carry <= 1'b0;
          n_shift <= '0;
          st <= VAZIO;
          erro <= 1'b0;
        end
        TX_LOAD: begin
          saida <= entrada;
          carry <= 1'b0;
          n_shift <= '0;
          n_load <= (n_load >= 2'd2) ? 2'd0 : n_load + 2'd1;
          st <= CARREGADO;
          erro <= 1'b0;
        end
        TX_SHIFTL: begin
          case (st)
            VAZIO, ESGOTADO: erro <= 1'b1;
            CARREGADO, DESLOCANDO: begin
              saida <= {saida[WIDTH-2:0], 1'b0};
              carry <= saida[WIDTH-1];
              n_shift <= ns_next;
              st <= (ns_next == 3'(MAX_SHIFT)) ? ESGOTADO : DESLOCANDO;
            end
            default: begin
              saida <= '0;
              carry <= 1'b0;
              n_shift <= '0;
              st <= VAZIO;
            end
          endcase
        end
        default: ;
      endcase
    end
  end
endmodule
